// File: rtl/conv_allocator_p.sv
// Convolution allocator compute unit: captures in-window pixels from the issue
// broadcast, pairs them with in-order weights, accumulates, then bias/rescale/leaky-ReLU/saturate.
module conv_allocator_p #(
    parameter int DATA_W     = 18,
    parameter int ACC_W      = 48,
    parameter int COORD_W    = 8,
    parameter int CNT_W      = 13,
    parameter int BUF_AW     = 9,
    parameter int FRAC_W     = 8,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [COORD_W-1:0]       center_x,
    input  logic [COORD_W-1:0]       center_y,
    input  logic                     center_we,
    input  logic [2:0]               filter_dim,
    input  logic [CNT_W-1:0]         filter_length,
    input  logic signed [DATA_W-1:0] filter_bias,
    input  logic                     img_valid,
    input  logic [COORD_W-1:0]       img_x,
    input  logic [COORD_W-1:0]       img_y,
    input  logic signed [DATA_W-1:0] img_data,
    output logic                     img_ready,
    input  logic                     flt_valid,
    input  logic signed [DATA_W-1:0] flt_data,
    output logic                     flt_ready,
    output logic                     result_valid,
    output logic signed [DATA_W-1:0] result_data,
    input  logic                     result_ready,
    output logic                     busy
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int DEPTH  = 1 << BUF_AW;
    localparam logic [BUF_AW:0] LVL_FULL = {1'b1, {BUF_AW{1'b0}}};
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_FINISH = 2'd2,
        S_OUTPUT = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [COORD_W-1:0]       cx_q, cx_d, cy_q, cy_d;
    logic [2:0]               r_q, r_d;
    logic [CNT_W-1:0]         len_q, len_d;
    logic signed [DATA_W-1:0] bias_q, bias_d;
    logic [CNT_W-1:0]         img_cnt_q, img_cnt_d;
    logic [CNT_W-1:0]         flt_cnt_q, flt_cnt_d;
    logic [CNT_W-1:0]         mac_cnt_q, mac_cnt_d;
    logic [BUF_AW-1:0]        img_wp_q, img_wp_d, img_rp_q, img_rp_d;
    logic [BUF_AW-1:0]        flt_wp_q, flt_wp_d, flt_rp_q, flt_rp_d;
    logic [BUF_AW:0]          img_lvl_q, img_lvl_d, flt_lvl_q, flt_lvl_d;
    logic                     p1_valid_q, p1_valid_d;
    logic signed [PROD_W-1:0] prod_q, prod_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [DATA_W-1:0] res_data_q, res_data_d;
    logic                     res_valid_q, res_valid_d;

    logic signed [DATA_W-1:0] img_mem [DEPTH];
    logic signed [DATA_W-1:0] flt_mem [DEPTH];

    logic signed [COORD_W:0]  dx_s, dy_s;
    logic [COORD_W:0]         adx_s, ady_s, r_ext_s;
    logic                     in_win_s;
    logic                     armed_s, arm_s;
    logic                     img_full_s, flt_full_s, img_want_s;
    logic                     img_push_s, flt_push_s, pop_s;
    logic signed [DATA_W-1:0] img_rd_s, flt_rd_s;
    logic signed [ACC_W-1:0]  prod_ext_s, bias_ext_s, sh_s, sum_s, act_s;
    logic signed [DATA_W-1:0] sat_s;

    assign r_ext_s    = {{(COORD_W-2){1'b0}}, r_q};
    assign img_rd_s   = img_mem[img_rp_q];
    assign flt_rd_s   = flt_mem[flt_rp_q];
    assign prod_ext_s = {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
    assign bias_ext_s = {{(ACC_W-DATA_W){bias_q[DATA_W-1]}}, bias_q};

    // Window match on a one-bit-wider signed difference so edges never wrap
    always_comb begin
        dx_s = $signed({1'b0, img_x}) - $signed({1'b0, cx_q});
        dy_s = $signed({1'b0, img_y}) - $signed({1'b0, cy_q});
        if (dx_s[COORD_W]) adx_s = $unsigned(-dx_s);
        else               adx_s = $unsigned(dx_s);
        if (dy_s[COORD_W]) ady_s = $unsigned(-dy_s);
        else               ady_s = $unsigned(dy_s);
        in_win_s = (adx_s <= r_ext_s) && (ady_s <= r_ext_s);
    end

    // Handshake decode; image beats are only back-pressured when they would be kept
    always_comb begin
        armed_s    = (state_q == S_ARMED);
        arm_s      = (state_q == S_IDLE) && center_we;
        img_full_s = (img_lvl_q == LVL_FULL);
        flt_full_s = (flt_lvl_q == LVL_FULL);
        img_want_s = armed_s && in_win_s && (img_cnt_q < len_q);
        img_ready  = !(img_want_s && img_full_s);
        img_push_s = img_valid && img_want_s && !img_full_s;
        flt_ready  = armed_s && !flt_full_s && (flt_cnt_q < len_q);
        flt_push_s = flt_valid && flt_ready;
        pop_s      = armed_s && (img_lvl_q != {(BUF_AW+1){1'b0}})
                             && (flt_lvl_q != {(BUF_AW+1){1'b0}});
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (center_we) state_d = S_ARMED;
                else           state_d = S_IDLE;
            end
            S_ARMED: begin
                if ((mac_cnt_q == len_q) && !p1_valid_q) state_d = S_FINISH;
                else                                     state_d = S_ARMED;
            end
            S_FINISH: state_d = S_OUTPUT;
            S_OUTPUT: begin
                if (result_ready) state_d = S_IDLE;
                else              state_d = S_OUTPUT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output scaling: drop fraction, add bias, leaky ReLU, clip to DATA_W
    always_comb begin
        sh_s  = acc_q >>> FRAC_W;
        sum_s = sh_s + bias_ext_s;
        if (sum_s[ACC_W-1]) begin
            if (LEAK_SHIFT == 0) act_s = {ACC_W{1'b0}};
            else                 act_s = sum_s >>> LEAK_SHIFT;
        end else begin
            act_s = sum_s;
        end
        if (act_s > SAT_MAX)      sat_s = SAT_MAX[DATA_W-1:0];
        else if (act_s < SAT_MIN) sat_s = SAT_MIN[DATA_W-1:0];
        else                      sat_s = act_s[DATA_W-1:0];
    end

    // Datapath next-state: config latch, FIFO pointers, MAC pipeline, result
    always_comb begin
        cx_d       = cx_q;
        cy_d       = cy_q;
        r_d        = r_q;
        len_d      = len_q;
        bias_d     = bias_q;
        img_cnt_d  = img_cnt_q + CNT_W'(img_push_s);
        flt_cnt_d  = flt_cnt_q + CNT_W'(flt_push_s);
        img_wp_d   = img_wp_q + BUF_AW'(img_push_s);
        flt_wp_d   = flt_wp_q + BUF_AW'(flt_push_s);
        img_rp_d   = img_rp_q + BUF_AW'(pop_s);
        flt_rp_d   = flt_rp_q + BUF_AW'(pop_s);
        img_lvl_d  = img_lvl_q + (BUF_AW+1)'(img_push_s) - (BUF_AW+1)'(pop_s);
        flt_lvl_d  = flt_lvl_q + (BUF_AW+1)'(flt_push_s) - (BUF_AW+1)'(pop_s);
        p1_valid_d = pop_s;
        if (pop_s) prod_d = PROD_W'(img_rd_s) * PROD_W'(flt_rd_s);
        else       prod_d = prod_q;
        if (p1_valid_q) begin
            acc_d     = acc_q + prod_ext_s;
            mac_cnt_d = mac_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            acc_d     = acc_q;
            mac_cnt_d = mac_cnt_q;
        end
        if (arm_s) begin
            cx_d      = center_x;
            cy_d      = center_y;
            r_d       = filter_dim >> 3'd1;
            len_d     = filter_length;
            bias_d    = filter_bias;
            img_cnt_d = {CNT_W{1'b0}};
            flt_cnt_d = {CNT_W{1'b0}};
            mac_cnt_d = {CNT_W{1'b0}};
            img_wp_d  = {BUF_AW{1'b0}};
            flt_wp_d  = {BUF_AW{1'b0}};
            img_rp_d  = {BUF_AW{1'b0}};
            flt_rp_d  = {BUF_AW{1'b0}};
            img_lvl_d = {(BUF_AW+1){1'b0}};
            flt_lvl_d = {(BUF_AW+1){1'b0}};
            acc_d     = {ACC_W{1'b0}};
        end else begin
            cx_d = cx_q;
        end
        case (state_q)
            S_FINISH: begin
                res_data_d  = sat_s;
                res_valid_d = 1'b1;
            end
            S_OUTPUT: begin
                res_data_d  = res_data_q;
                res_valid_d = !result_ready;
            end
            default: begin
                res_data_d  = res_data_q;
                res_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cx_q        <= {COORD_W{1'b0}};
            cy_q        <= {COORD_W{1'b0}};
            r_q         <= 3'd0;
            len_q       <= {CNT_W{1'b0}};
            bias_q      <= {DATA_W{1'b0}};
            img_cnt_q   <= {CNT_W{1'b0}};
            flt_cnt_q   <= {CNT_W{1'b0}};
            mac_cnt_q   <= {CNT_W{1'b0}};
            img_wp_q    <= {BUF_AW{1'b0}};
            flt_wp_q    <= {BUF_AW{1'b0}};
            img_rp_q    <= {BUF_AW{1'b0}};
            flt_rp_q    <= {BUF_AW{1'b0}};
            img_lvl_q   <= {(BUF_AW+1){1'b0}};
            flt_lvl_q   <= {(BUF_AW+1){1'b0}};
            p1_valid_q  <= 1'b0;
            prod_q      <= {PROD_W{1'b0}};
            acc_q       <= {ACC_W{1'b0}};
            res_data_q  <= {DATA_W{1'b0}};
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            r_q         <= r_d;
            len_q       <= len_d;
            bias_q      <= bias_d;
            img_cnt_q   <= img_cnt_d;
            flt_cnt_q   <= flt_cnt_d;
            mac_cnt_q   <= mac_cnt_d;
            img_wp_q    <= img_wp_d;
            flt_wp_q    <= flt_wp_d;
            img_rp_q    <= img_rp_d;
            flt_rp_q    <= flt_rp_d;
            img_lvl_q   <= img_lvl_d;
            flt_lvl_q   <= flt_lvl_d;
            p1_valid_q  <= p1_valid_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
        end
    end

    // FIFO storage; emptiness is tracked by the level counters, so no reset
    always_ff @(posedge clk) begin
        if (img_push_s) img_mem[img_wp_q] <= img_data;
        if (flt_push_s) flt_mem[flt_wp_q] <= flt_data;
    end

    assign result_valid = res_valid_q;
    assign result_data  = res_data_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_conv_allocator_p.sv
// Scoreboard bench for conv_allocator_p: a leaky instance and a plain-ReLU instance share stimulus.
module tb_conv_allocator_p;
    localparam int DW = 18;
    localparam int CW = 8;
    localparam int NW = 13;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [CW-1:0]        center_x, center_y, img_x, img_y;
    logic                 center_we, img_valid, flt_valid, result_ready;
    logic [2:0]           filter_dim;
    logic [NW-1:0]        filter_length;
    logic signed [DW-1:0] filter_bias, img_data, flt_data;
    logic                 img_ready0, flt_ready0, rv0, busy0;
    logic                 img_ready1, flt_ready1, rv1, busy1;
    logic signed [DW-1:0] rd0, rd1;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int rv_rise = 0;
    logic rv_prev = 1'b0;

    typedef struct { longint e0; longint e1; } exp_t;
    exp_t   sbq[$];
    int     q_x[$];
    int     q_y[$];
    longint q_px[$];
    longint q_w[$];

    conv_allocator_p dut0 (
        .clk(clk), .rst(rst), .center_x(center_x), .center_y(center_y), .center_we(center_we),
        .filter_dim(filter_dim), .filter_length(filter_length), .filter_bias(filter_bias),
        .img_valid(img_valid), .img_x(img_x), .img_y(img_y), .img_data(img_data), .img_ready(img_ready0),
        .flt_valid(flt_valid), .flt_data(flt_data), .flt_ready(flt_ready0),
        .result_valid(rv0), .result_data(rd0), .result_ready(result_ready), .busy(busy0));

    conv_allocator_p #(.LEAK_SHIFT(0)) dut1 (
        .clk(clk), .rst(rst), .center_x(center_x), .center_y(center_y), .center_we(center_we),
        .filter_dim(filter_dim), .filter_length(filter_length), .filter_bias(filter_bias),
        .img_valid(img_valid), .img_x(img_x), .img_y(img_y), .img_data(img_data), .img_ready(img_ready1),
        .flt_valid(flt_valid), .flt_data(flt_data), .flt_ready(flt_ready1),
        .result_valid(rv1), .result_data(rd1), .result_ready(result_ready), .busy(busy1));

    task automatic chk(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic longint post(input longint acc, input longint bias, input int leak);
        longint s;
        s = (acc >>> 8) + bias;
        if (s < 0) s = (leak == 0) ? 64'sd0 : (s >>> leak);
        if (s > 131071) s = 131071;
        if (s < -131072) s = -131072;
        return s;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Result monitor: pops the scoreboard on every result handshake
    always @(negedge clk) begin
        exp_t e;
        if (rv0 && !rv_prev) rv_rise = cyc;
        rv_prev = rv0;
        if (rst && rv0 && result_ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("result_data", rd0, e.e0);
                chk("result_data_noleak", rd1, e.e1);
                chk("result_valid_noleak", rv1, 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        q_x.delete(); q_y.delete(); q_px.delete(); q_w.delete();
    endtask

    task automatic send_img(input int x, input int y, input longint d, output int xc);
        int guard;
        guard = 0;
        img_valid = 1'b1; img_x = CW'(x); img_y = CW'(y); img_data = DW'(d);
        @(negedge clk);
        while (!img_ready0 && guard < 3000) begin @(negedge clk); guard++; end
        if (guard >= 3000) chk("img_ready_timeout", 0, 1);
        xc = cyc;
        tick();
        img_valid = 1'b0;
    endtask

    task automatic send_flt(input longint d);
        int guard;
        guard = 0;
        flt_valid = 1'b1; flt_data = DW'(d);
        @(negedge clk);
        while (!flt_ready0 && guard < 3000) begin @(negedge clk); guard++; end
        if (guard >= 3000) chk("flt_ready_timeout", 0, 1);
        tick();
        flt_valid = 1'b0;
    endtask

    task automatic plan(input int cx, input int cy, input int dim, input int len, input int bias);
        longint acc;
        int k;
        exp_t e;
        acc = 0; k = 0;
        for (int i = 0; i < q_x.size(); i++) begin
            if (k < len && iabs(q_x[i] - cx) <= dim / 2 && iabs(q_y[i] - cy) <= dim / 2) begin
                acc += q_px[i] * q_w[k];
                k++;
            end
        end
        e.e0 = post(acc, bias, 3);
        e.e1 = post(acc, bias, 0);
        sbq.push_back(e);
    endtask

    task automatic arm(input int cx, input int cy, input int dim, input int len, input int bias);
        center_x = CW'(cx); center_y = CW'(cy); filter_dim = 3'(dim);
        filter_length = NW'(len); filter_bias = DW'(bias); center_we = 1'b1;
        tick();
        center_we = 1'b0;
        chk("busy_armed", busy0, 1);
    endtask

    task automatic drive_seq(input int cx, input int cy, input int dim, input int len, output int last_cap);
        int xc, cap;
        cap = 0; last_cap = 0;
        for (int i = 0; i < q_w.size(); i++) send_flt(q_w[i]);
        for (int i = 0; i < q_x.size(); i++) begin
            send_img(q_x[i], q_y[i], q_px[i], xc);
            if (cap < len && iabs(q_x[i] - cx) <= dim / 2 && iabs(q_y[i] - cy) <= dim / 2) begin
                cap++;
                if (cap == len) last_cap = xc;
            end
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((sbq.size() != 0 || busy0) && guard < 3000) begin tick(); guard++; end
        if (guard >= 3000) chk("idle_timeout", 0, 1);
    endtask

    task automatic load_raster(input longint pix, input longint wt, input int nw);
        clr();
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 32; x++) begin
                q_x.push_back(x); q_y.push_back(y); q_px.push_back(pix);
            end
        for (int k = 0; k < nw; k++) q_w.push_back(wt);
    endtask

    task automatic run_job(input int cx, input int cy, input int dim, input int len, input int bias,
                           input string tag);
        int lc;
        plan(cx, cy, dim, len, bias);
        arm(cx, cy, dim, len, bias);
        drive_seq(cx, cy, dim, len, lc);
        wait_idle();
        if (lc > 0) chk({tag, "_latency"}, rv_rise - lc, 5);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_img_ready"}, img_ready0, 1);
        chk({tag, "_flt_ready"}, flt_ready0, 0);
        chk({tag, "_result_valid"}, rv0, 0);
        chk({tag, "_result_data"}, rd0, 0);
        chk({tag, "_busy"}, busy0, 0);
        chk({tag, "_img_ready_nl"}, img_ready1, 1);
        chk({tag, "_flt_ready_nl"}, flt_ready1, 0);
        chk({tag, "_busy_nl"}, busy1, 0);
    endtask

    initial begin
        int dummy0, dummy1;
        center_x = '0; center_y = '0; center_we = 1'b0; filter_dim = 3'd1;
        filter_length = '0; filter_bias = '0; img_valid = 1'b0; img_x = '0; img_y = '0;
        img_data = '0; flt_valid = 1'b0; flt_data = '0; result_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        tick();

        // Scenario 1: 3x3 window at (10,10) over a 32x32 raster of 256s
        load_raster(256, 256, 9);
        run_job(10, 10, 3, 9, 0, "s1");

        // Scenario 2: negative weights, leaky vs plain ReLU
        load_raster(256, -256, 9);
        run_job(10, 10, 3, 9, 0, "s2");

        // Scenario 3: far-edge beat must not wrap into a window at the origin
        clr();
        q_x = '{255, 2, 1}; q_y = '{0, 2, 0}; q_px = '{1000, 300, 500};
        q_w = '{256, 512};
        run_job(0, 0, 5, 2, 0, "s3");

        // Scenario 4: filter FIFO fills at 512, then pixels drain it to 600 MACCs
        clr();
        for (int k = 0; k < 600; k++) begin
            q_x.push_back(5); q_y.push_back(5);
            q_px.push_back(((k % 11) - 5) * 64);
            q_w.push_back(((k % 13) - 6) * 16);
        end
        plan(5, 5, 1, 600, 7);
        arm(5, 5, 1, 600, 7);
        for (int k = 0; k < 512; k++) send_flt(q_w[k]);
        flt_valid = 1'b1; flt_data = DW'(q_w[512]);
        repeat (4) begin
            @(negedge clk);
            chk("flt_ready_full", flt_ready0, 0);
        end
        tick();
        fork
            begin
                for (int k = 512; k < 600; k++) send_flt(q_w[k]);
            end
            begin
                for (int k = 0; k < 600; k++) send_img(q_x[k], q_y[k], q_px[k], dummy0);
            end
        join
        wait_idle();

        // Scenario 5: saturation and output hold under back-pressure
        clr();
        for (int k = 0; k < 9; k++) begin
            q_x.push_back(10); q_y.push_back(10); q_px.push_back(131071); q_w.push_back(131071);
        end
        result_ready = 1'b0;
        plan(10, 10, 3, 9, 0);
        arm(10, 10, 3, 9, 0);
        drive_seq(10, 10, 3, 9, dummy1);
        begin
            int guard;
            guard = 0;
            while (!rv0 && guard < 100) begin @(negedge clk); guard++; end
            if (guard >= 100) chk("s5_valid_timeout", 0, 1);
        end
        repeat (10) begin
            @(negedge clk);
            chk("s5_hold_valid", rv0, 1);
            chk("s5_hold_data", rd0, 131071);
        end
        @(posedge clk);
        #1 result_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("s5_busy_after", busy0, 0);
        chk("s5_valid_after", rv0, 0);
        chk("s5_busy_after_nl", busy1, 0);
        tick();

        // Scenario 6: reset after four MACCs, then a clean rerun
        clr();
        for (int k = 0; k < 4; k++) begin
            q_x.push_back(10); q_y.push_back(10); q_px.push_back(256);
        end
        for (int k = 0; k < 9; k++) q_w.push_back(256);
        arm(10, 10, 3, 9, 0);
        drive_seq(10, 10, 3, 9, dummy1);
        repeat (4) tick();
        chk("s6_busy_before_reset", busy0, 1);
        rst = 1'b0;
        #1;
        check_reset_outputs("s6_reset");
        #1 rst = 1'b1;
        tick();
        load_raster(256, 256, 9);
        run_job(10, 10, 3, 9, 0, "s6_rerun");

        chk("scoreboard_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/conv_allocator_p.md
Name: conv_allocator_p

Overview:
- Parametrised next-generation allocator: one compute unit per DSP that latches a window centre and captures in-window image pixels from the issue broadcast.
- Buffers image pixels and in-order filter weights in internal FIFOs, then runs signed MACCs.
- Completes the output path: bias add, fixed-point rescale, leaky ReLU, saturation, and a valid/ready result handshake.
- Sits between the issue stage / filter weight source and the output collector.

Parameters:
- DATA_W, 18, pixel/weight/bias/result width (signed two's complement)
- ACC_W, 48, accumulator width
- COORD_W, 8, x/y coordinate width (unsigned)
- CNT_W, 13, filter_length / counter width
- BUF_AW, 9, log2 depth of each FIFO (image and filter), 512 entries each
- FRAC_W, 8, fractional bits of pixel×weight product removed before output
- LEAK_SHIFT, 3, negative values are arithmetic-shifted right by this amount; 0 = no leak (plain ReLU clamps negatives to 0)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- center_x  in  COORD_W  window centre x
- center_y  in  COORD_W  window centre y
- center_we  in  1  latch centre/config and arm
- filter_dim  in  3  window width/height (odd, 1..7)
- filter_length  in  CNT_W  MACCs per result (W*H*D)
- filter_bias  in  DATA_W  bias, same scale as output
- img_valid  in  1  issue beat valid
- img_x  in  COORD_W  issue beat x
- img_y  in  COORD_W  issue beat y
- img_data  in  DATA_W  issue pixel
- img_ready  out  1  beat accepted
- flt_valid  in  1  weight valid
- flt_data  in  DATA_W  weight
- flt_ready  out  1  weight accepted
- result_valid  out  1  result available
- result_data  out  DATA_W  activated result
- result_ready  in  1  collector accepts result
- busy  out  1  not IDLE

Behaviour:
- Reset (rst low, async): state IDLE; FIFOs empty; all counters 0; acc 0; result_valid 0; result_data 0; busy 0.
  - img_ready 1 and flt_ready 0 at reset.
  - Reset mid-operation discards all buffered data and any pending result.
- States:
  - IDLE: center_we → ARMED. On that edge, latch center_x, center_y, radius r = filter_dim>>1, filter_length and filter_bias; clear counters and acc.
  - ARMED: capture and MACC. Transition → FINISH when mac_cnt == filter_length and the pipeline is empty. If filter_length == 0, go → FINISH on the next cycle.
  - FINISH: one cycle; computes result.
  - OUTPUT: hold result until result_ready → IDLE.
  - center_we outside IDLE is ignored.
- Window match:
  - in_win = |img_x−cx| <= r and |img_y−cy| <= r, computed with COORD_W+1-bit signed difference, so there is no wrap at 0 or 2^COORD_W−1.
- Image handshake: beat transfers when img_valid && img_ready.
  - img_ready is low only in ARMED when in_win && img_fifo full && img_cnt < filter_length. It is high otherwise.
  - Out-of-window beats, beats arriving when not ARMED, and in-window beats after img_cnt == filter_length are accepted and discarded.
  - Accepted in-window beats are pushed and increment img_cnt.
- Filter handshake: flt_ready = ARMED && !flt_fifo full && flt_cnt < filter_length.
- MACC pipeline:
  - Pop both FIFOs in the same cycle when both are non-empty.
  - Stage 1 registers the product a*b (2·DATA_W signed).
  - Stage 2 does acc += sign-extended product and increments mac_cnt.
  - Push and pop in the same cycle on a full FIFO is allowed. The FIFO pointers wrap modulo 2^BUF_AW.
- FINISH arithmetic:
  - s = (acc >>> FRAC_W) + sext(filter_bias).
  - If s < 0: s = (LEAK_SHIFT == 0) ? 0 : s >>> LEAK_SHIFT.
  - Saturate to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - Register into result_data; result_valid rises the next cycle (OUTPUT).
- Latency: the last weight/pixel pop leads to result_valid after 4 cycles.
- result_data and result_valid stay stable while result_ready is low. result_valid falls on the cycle after the handshake.
- A simultaneous center_we and result handshake in OUTPUT is ignored; the allocator must be re-armed while in IDLE.

Test Plan:
1. filter_dim=3, centre (10,10), filter_length=9, bias=0, FRAC_W=8 → raster image x,y 0..31 with all pixels 256 and 9 weights of 256. Required: exactly 9 beats captured, result_valid after last MACC+4, result_data = 2304.
2. Same as 1 with weights = −256 → result_data = −2304>>>3 = −288. With LEAK_SHIFT=0 the result is 0.
3. Centre (0,0), dim=5, issue beat (255,0) → discarded, with no wrap match. Beats (2,2) and (1,0) are captured.
4. filter_length=600, flt_valid held 1, no image beats → flt_ready drops after 512 weights. Then stream matching pixels → all 600 MACCs complete and flt_ready reasserts.
5. Large positive values (pixel=weight=2^17−1, length=9) → result_data saturates to 131071. Hold result_ready=0 for 10 cycles → output stays stable. Then pulse result_ready → IDLE, busy=0.
6. Assert rst low mid-ARMED after 4 MACCs → all outputs return to reset values immediately. Re-arm and run scenario 1 → result 2304.
